// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: latches an instruction, reads two registers across
// ISSUE and WAIT, then presents a decoded operand bundle in OUT.
module operand_fetch_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     INSTR,
    input  logic                      INSTR_VALID,
    output logic                      INSTR_READY,
    output logic [REG_ADDR_WIDTH-1:0] RF_ADDR_R1,
    output logic [REG_ADDR_WIDTH-1:0] RF_ADDR_R2,
    output logic                      RF_READ,
    input  logic [DATA_WIDTH-1:0]     RF_DATA_R1,
    input  logic [DATA_WIDTH-1:0]     RF_DATA_R2,
    output logic                      OP_VALID,
    input  logic                      OP_READY,
    output logic [5:0]                OP_OPCODE,
    output logic [5:0]                OP_FUNCT,
    output logic [4:0]                OP_SHAMT,
    output logic [REG_ADDR_WIDTH-1:0] OP_DEST,
    output logic [DATA_WIDTH-1:0]     OP_A,
    output logic [DATA_WIDTH-1:0]     OP_B,
    output logic [DATA_WIDTH-1:0]     OP_IMM
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [31:0]           instr_q;
    logic [DATA_WIDTH-1:0] op_a_q;
    logic [DATA_WIDTH-1:0] op_b_q;
    logic                  accept;
    logic                  reading;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [31:0] imm_ext;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign imm    = instr_q[15:0];
    assign jaddr  = instr_q[25:0];

    // A new instruction can slip in on the same edge the bundle is consumed.
    assign INSTR_READY = (state == S_IDLE) || ((state == S_OUT) && OP_READY);
    assign accept      = INSTR_VALID && INSTR_READY;
    assign reading     = (state == S_ISSUE) || (state == S_WAIT);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = accept ? S_ISSUE : S_IDLE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  state_next = S_OUT;
            S_OUT: begin
                if (OP_READY) state_next = accept ? S_ISSUE : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            instr_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) instr_q <= INSTR[31:0];
            // Register r0 always reads as zero regardless of the file contents.
            if (state == S_WAIT) begin
                op_a_q <= (rs == 5'd0) ? '0 : RF_DATA_R1;
                op_b_q <= (rt == 5'd0) ? '0 : RF_DATA_R2;
            end
        end
    end

    always_comb begin
        case (opcode)
            6'h0C, 6'h0D: imm_ext = {16'h0000, imm};
            6'h0F:        imm_ext = {imm, 16'h0000};
            6'h02, 6'h03: imm_ext = {6'b000000, jaddr};
            default:      imm_ext = {{16{imm[15]}}, imm};
        endcase
    end

    always_comb begin
        case (opcode)
            6'h00:   OP_DEST = REG_ADDR_WIDTH'(rd);
            6'h03:   OP_DEST = REG_ADDR_WIDTH'(31);
            6'h02:   OP_DEST = '0;
            default: OP_DEST = REG_ADDR_WIDTH'(rt);
        endcase
    end

    assign RF_READ    = reading;
    assign RF_ADDR_R1 = reading ? REG_ADDR_WIDTH'(rs) : '0;
    assign RF_ADDR_R2 = reading ? REG_ADDR_WIDTH'(rt) : '0;
    assign OP_VALID   = (state == S_OUT);
    assign OP_OPCODE  = opcode;
    assign OP_FUNCT   = instr_q[5:0];
    assign OP_SHAMT   = instr_q[10:6];
    assign OP_A       = op_a_q;
    assign OP_B       = op_b_q;
    assign OP_IMM     = DATA_WIDTH'(imm_ext);

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus random
// instructions compared against a behavioural decode model.
module tb_operand_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [4:0]  RF_ADDR_R1;
    logic [4:0]  RF_ADDR_R2;
    logic        RF_READ;
    logic [31:0] RF_DATA_R1;
    logic [31:0] RF_DATA_R2;
    logic        OP_VALID;
    logic        OP_READY;
    logic [5:0]  OP_OPCODE;
    logic [5:0]  OP_FUNCT;
    logic [4:0]  OP_SHAMT;
    logic [4:0]  OP_DEST;
    logic [31:0] OP_A;
    logic [31:0] OP_B;
    logic [31:0] OP_IMM;

    logic [31:0] rf [32];
    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } bundle_t;

    operand_fetch_stage dut (
        .CLK(CLK), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2),
        .RF_READ(RF_READ), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2),
        .OP_VALID(OP_VALID), .OP_READY(OP_READY), .OP_OPCODE(OP_OPCODE),
        .OP_FUNCT(OP_FUNCT), .OP_SHAMT(OP_SHAMT), .OP_DEST(OP_DEST),
        .OP_A(OP_A), .OP_B(OP_B), .OP_IMM(OP_IMM)
    );

    always #5 CLK = ~CLK;

    // Register file model; r0 deliberately holds junk so zero-forcing is visible.
    assign RF_DATA_R1 = rf[RF_ADDR_R1];
    assign RF_DATA_R2 = rf[RF_ADDR_R2];

    function automatic bundle_t model(input logic [31:0] ins);
        bundle_t m;
        int unsigned op    = ins[31:26];
        int unsigned rs    = ins[25:21];
        int unsigned rt    = ins[20:16];
        int unsigned imm16 = ins[15:0];
        m.opcode = ins[31:26];
        m.funct  = ins[5:0];
        m.shamt  = ins[10:6];
        if (op == 0)      m.dest = ins[15:11];
        else if (op == 3) m.dest = 5'd31;
        else if (op == 2) m.dest = 5'd0;
        else              m.dest = ins[20:16];
        if (op == 12 || op == 13)   m.imm = imm16;
        else if (op == 15)          m.imm = imm16 * 65536;
        else if (op == 2 || op == 3) m.imm = ins % 32'h0400_0000;
        else if (imm16 >= 32768)    m.imm = imm16 + 32'hFFFF_0000;
        else                        m.imm = imm16;
        m.a = (rs == 0) ? 32'd0 : rf[rs];
        m.b = (rt == 0) ? 32'd0 : rf[rt];
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_bundle(input logic [31:0] ins);
        bundle_t m = model(ins);
        check("op_valid", 32'(OP_VALID), 32'd1);
        check("op_opcode", 32'(OP_OPCODE), 32'(m.opcode));
        check("op_funct", 32'(OP_FUNCT), 32'(m.funct));
        check("op_shamt", 32'(OP_SHAMT), 32'(m.shamt));
        check("op_dest", 32'(OP_DEST), 32'(m.dest));
        check("op_a", OP_A, m.a);
        check("op_b", OP_B, m.b);
        check("op_imm", OP_IMM, m.imm);
    endtask

    task automatic check_reading(input string tag, input logic [31:0] ins);
        check({tag, "_rf_read"}, 32'(RF_READ), 32'd1);
        check({tag, "_addr_r1"}, 32'(RF_ADDR_R1), 32'(ins[25:21]));
        check({tag, "_addr_r2"}, 32'(RF_ADDR_R2), 32'(ins[20:16]));
        check({tag, "_op_valid"}, 32'(OP_VALID), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_instr_ready"}, 32'(INSTR_READY), 32'd1);
        check({tag, "_op_valid"}, 32'(OP_VALID), 32'd0);
        check({tag, "_rf_read"}, 32'(RF_READ), 32'd0);
        check({tag, "_addrs"}, {RF_ADDR_R1, RF_ADDR_R2}, 32'd0);
    endtask

    task automatic wait_ready;
        int n = 0;
        while (INSTR_READY !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        check("instr_ready_timeout", 32'(INSTR_READY), 32'd1);
    endtask

    // Accept an instruction from IDLE and walk through ISSUE and WAIT.
    task automatic apply_stimulus(input logic [31:0] ins);
        wait_ready;
        INSTR       = ins;
        INSTR_VALID = 1'b1;
        tick;
        INSTR_VALID = 1'b0;
        check_reading("issue", ins);
        tick;
        check_reading("wait", ins);
    endtask

    task automatic check_output(input logic [31:0] ins);
        tick;
        check("out_instr_ready", 32'(INSTR_READY), 32'd0);
        check("out_rf_read", 32'(RF_READ), 32'd0);
        check_bundle(ins);
    endtask

    task automatic consume;
        OP_READY = 1'b1;
        #1;
        check("consume_instr_ready", 32'(INSTR_READY), 32'd1);
        tick;
        OP_READY = 1'b0;
        check_idle_outputs("after_consume");
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] r;
        logic [5:0]  ops [9];
        ops = '{6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0F, 6'h08, 6'h23, 6'h2B};
        RST = 1'b1; INSTR = '0; INSTR_VALID = 1'b0; OP_READY = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_BEEF;
        tick; tick;
        RST = 1'b0;
        check_idle_outputs("reset");
        check("reset_bundle", OP_A | OP_B | OP_IMM | 32'(OP_DEST) | 32'(OP_OPCODE), 32'd0);

        rf[3] = 32'h1E; rf[4] = 32'h28;
        apply_stimulus(32'h0064_2820);
        check_output(32'h0064_2820);
        check("r_type_a", OP_A, 32'h1E);
        check("r_type_b", OP_B, 32'h28);
        check("r_type_dest", 32'(OP_DEST), 32'd5);
        check("r_type_funct", 32'(OP_FUNCT), 32'h20);
        consume;

        apply_stimulus(32'h2066_FFFF);
        check_output(32'h2066_FFFF);
        check("addi_imm", OP_IMM, 32'hFFFF_FFFF);
        check("addi_dest", 32'(OP_DEST), 32'd6);
        consume;
        apply_stimulus(32'h3467_8000);
        check_output(32'h3467_8000);
        check("ori_imm", OP_IMM, 32'h0000_8000);
        check("ori_dest", 32'(OP_DEST), 32'd7);
        consume;
        apply_stimulus(32'h3C08_1234);
        check_output(32'h3C08_1234);
        check("lui_imm", OP_IMM, 32'h1234_0000);
        check("lui_a", OP_A, 32'd0);
        consume;
        apply_stimulus(32'h0C00_0010);
        check_output(32'h0C00_0010);
        check("jal_dest", 32'(OP_DEST), 32'd31);
        check("jal_imm", OP_IMM, 32'h10);
        consume;
        apply_stimulus(32'h0800_0010);
        check_output(32'h0800_0010);
        check("jmp_dest", 32'(OP_DEST), 32'd0);
        consume;

        // Both reads hit r0 while the file returns junk there.
        for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_BEEF;
        apply_stimulus(32'h0000_3020);
        check_output(32'h0000_3020);
        check("r0_a", OP_A, 32'd0);
        check("r0_b", OP_B, 32'd0);

        // Backpressure, then a back-to-back handover on the consuming edge.
        for (int k = 0; k < 5; k++) begin
            tick;
            check("stall_instr_ready", 32'(INSTR_READY), 32'd0);
            check_bundle(32'h0000_3020);
        end
        rf[9] = 32'h1111_2222; rf[10] = 32'h3333_4444;
        ins = 32'h012A_5822;
        OP_READY = 1'b1; INSTR = ins; INSTR_VALID = 1'b1;
        #1;
        check("handover_instr_ready", 32'(INSTR_READY), 32'd1);
        tick;
        OP_READY = 1'b0; INSTR_VALID = 1'b0;
        check_reading("handover_issue", ins);
        tick;
        check_reading("handover_wait", ins);
        check_output(ins);
        consume;

        // Reset in WAIT drops the instruction.
        apply_stimulus(32'h012A_5822);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        check_idle_outputs("wait_reset");
        for (int k = 0; k < 4; k++) begin
            tick;
            check("wait_reset_no_valid", 32'(OP_VALID), 32'd0);
        end

        // Reset wins over a simultaneous acceptance.
        INSTR = 32'h012A_5822; INSTR_VALID = 1'b1; RST = 1'b1;
        tick;
        RST = 1'b0; INSTR_VALID = 1'b0;
        check_idle_outputs("reset_vs_accept");

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            r   = $urandom;
            ins = {ops[$urandom_range(0, 8)], r[25:0]};
            apply_stimulus(ins);
            check_output(ins);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                tick;
                check_bundle(ins);
            end
            consume;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
